// File: rtl/serial_ula_ctrl.sv
// Bit-serial controller for an external 1-bit ULA: feeds operand bits LSB-first,
// chains the carry bit-to-bit and assembles the WIDTH-bit result.
module serial_ula_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       opIn,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             ulaA,
  output logic             ulaB,
  output logic             ulaCarryIn,
  output logic [1:0]       ulaOp,
  input  logic             ulaC,
  input  logic             ulaCarryOut
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [1:0]       op_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt;
  logic             capture;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (start) begin
        capture   = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath registers are reset too, since result/carryOut and the
  // ULA-side outputs must read 0 the instant reset is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      res_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (capture) begin
      a_reg     <= aIn;
      b_reg     <= bIn;
      op_reg    <= opIn;
      carry_reg <= carryIn;
      cnt       <= '0;
    end else if (state == RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry_reg <= ulaCarryOut;
      cnt       <= cnt + CW'(1);
      res_reg   <= {ulaC, res_reg[WIDTH-1:1]};
      // carryOut only moves on the final bit so it holds the previous value during RUN
      if (last_bit) cout_reg <= ulaCarryOut;
    end
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign result     = res_reg;
  assign carryOut   = cout_reg;
  assign ulaA       = busy & a_reg[0];
  assign ulaB       = busy & b_reg[0];
  assign ulaCarryIn = busy & carry_reg;
  assign ulaOp      = busy ? op_reg : 2'b00;

endmodule
